// File: rtl/mole_game_sequencer.sv
// mole_game_sequencer: round controller for Whack Some Moles.
// Latches the level on start, runs IDLE -> READY -> PLAY -> OVER, schedules
// mole pop-ups from a free-running LFSR, times the round and keeps score.
// Optional build macro: PAUSE_TOGGLE_EN adds a pause input, a paused output
// and a PAUSED state (reported as game_state=1 together with paused=1).
`timescale 1ns/1ps

module mole_game_sequencer #(
    parameter int unsigned GAME_SECONDS  = 30,
    parameter int unsigned READY_SECONDS = 3,
    parameter int unsigned PERIOD_L1     = 12,
    parameter int unsigned PERIOD_L2     = 8,
    parameter int unsigned PERIOD_L3     = 5,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] selected_level,
    input  logic       tick_1hz,
    input  logic       tick_fast,
    input  logic       hit,
    input  logic [2:0] hit_idx,
`ifdef PAUSE_TOGGLE_EN
    input  logic       pause,
    output logic       paused,
`endif
    output logic [1:0] game_state,
    output logic [1:0] active_level,
    output logic [5:0] time_left,
    output logic       mole_up,
    output logic [2:0] mole_idx,
    output logic [6:0] score
);

`ifdef PAUSE_TOGGLE_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_READY  = 3'd1,
        ST_PLAY   = 3'd2,
        ST_OVER   = 3'd3,
        ST_PAUSED = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READY = 3'd1,
        ST_PLAY  = 3'd2,
        ST_OVER  = 3'd3
    } state_t;
`endif

    state_t     state;
    logic [7:0] lfsr;
    logic [7:0] spawn_cnt;
    logic [7:0] period_m1;
    logic       hit_ok;
    logic       spawn_now;
    logic [6:0] score_inc;

    // Spawn period for the latched level, plus hit/spawn qualifiers for PLAY.
    always_comb begin
        period_m1 = 8'(PERIOD_L1 - 1);
        case (active_level)
            2'd2:    period_m1 = 8'(PERIOD_L2 - 1);
            2'd3:    period_m1 = 8'(PERIOD_L3 - 1);
            default: period_m1 = 8'(PERIOD_L1 - 1);
        endcase
        hit_ok    = hit && mole_up && (hit_idx == mole_idx);
        spawn_now = tick_fast && (spawn_cnt == period_m1);
        score_inc = (score >= 7'd99) ? 7'd99 : score + 7'd1;
    end

    // Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4), advancing every clock
    // so the mole positions depend on when the player acts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    // Round state machine; every output is a register updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            game_state   <= 2'd0;
            active_level <= 2'd0;
            time_left    <= 6'd0;
            mole_up      <= 1'b0;
            mole_idx     <= 3'd0;
            score        <= 7'd0;
            spawn_cnt    <= 8'd0;
`ifdef PAUSE_TOGGLE_EN
            paused       <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && (selected_level != 2'd0)) begin
                        state        <= ST_READY;
                        game_state   <= 2'd1;
                        active_level <= selected_level;
                        time_left    <= 6'(READY_SECONDS);
                        score        <= 7'd0;
                    end
                end
                ST_READY: begin
                    if (tick_1hz) begin
                        if (time_left == 6'd1) begin
                            state      <= ST_PLAY;
                            game_state <= 2'd2;
                            time_left  <= 6'(GAME_SECONDS);
                            spawn_cnt  <= 8'd0;
                            mole_up    <= 1'b0;
                        end else begin
                            time_left <= time_left - 6'd1;
                        end
                    end
                end
                ST_PLAY: begin
`ifdef PAUSE_TOGGLE_EN
                    if (pause) begin
                        state      <= ST_PAUSED;
                        game_state <= 2'd1;
                        paused     <= 1'b1;
                    end else begin
`endif
                    // Later assignments win: a spawn re-raises a mole just
                    // whacked, and the end of the round lowers everything.
                    if (hit_ok) begin
                        score   <= score_inc;
                        mole_up <= 1'b0;
                    end
                    if (tick_fast) begin
                        if (spawn_now) begin
                            spawn_cnt <= 8'd0;
                            mole_up   <= 1'b1;
                            mole_idx  <= lfsr[2:0];
                        end else begin
                            spawn_cnt <= spawn_cnt + 8'd1;
                        end
                    end
                    if (tick_1hz) begin
                        if (time_left == 6'd1) begin
                            state      <= ST_OVER;
                            game_state <= 2'd3;
                            time_left  <= 6'd0;
                            mole_up    <= 1'b0;
                        end else begin
                            time_left <= time_left - 6'd1;
                        end
                    end
`ifdef PAUSE_TOGGLE_EN
                    end
`endif
                end
                ST_OVER: begin
                    if (start) begin
                        state      <= ST_IDLE;
                        game_state <= 2'd0;
                    end
                end
`ifdef PAUSE_TOGGLE_EN
                ST_PAUSED: begin
                    if (pause) begin
                        state      <= ST_PLAY;
                        game_state <= 2'd2;
                        paused     <= 1'b0;
                    end
                end
`endif
                default: begin
                    state      <= ST_IDLE;
                    game_state <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mole_game_sequencer.sv
// tb_mole_game_sequencer: directed bench for mole_game_sequencer with a
// rule-level reference model checked every cycle, plus literal spot checks.
// Optional build macro: PAUSE_TOGGLE_EN exercises the pause feature.
`timescale 1ns/1ps

module tb_mole_game_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] selected_level;
    logic       tick_1hz;
    logic       tick_fast;
    logic       hit;
    logic [2:0] hit_idx;
`ifdef PAUSE_TOGGLE_EN
    logic       pause;
    logic       paused;
`endif
    logic [1:0] game_state;
    logic [1:0] active_level;
    logic [5:0] time_left;
    logic       mole_up;
    logic [2:0] mole_idx;
    logic [6:0] score;

    int total = 0;
    int bad   = 0;

    // Reference model: 0=IDLE 1=READY 2=PLAY 3=OVER 4=PAUSED
    int         m_state, m_level, m_time, m_up, m_idx, m_score, m_cnt;
    logic [7:0] m_lfsr;
    logic [7:0] lfsr_pre;

    mole_game_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .selected_level (selected_level),
        .tick_1hz       (tick_1hz),
        .tick_fast      (tick_fast),
        .hit            (hit),
        .hit_idx        (hit_idx),
`ifdef PAUSE_TOGGLE_EN
        .pause          (pause),
        .paused         (paused),
`endif
        .game_state     (game_state),
        .active_level   (active_level),
        .time_left      (time_left),
        .mole_up        (mole_up),
        .mole_idx       (mole_idx),
        .score          (score)
    );

    // 100 MHz-style free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int period_of(input int lvl);
        if (lvl == 3) return 5;
        if (lvl == 2) return 8;
        return 12;
    endfunction

    task automatic check_output(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model advancing by the game rules on each clock or reset
    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_state = 0; m_level = 0; m_time = 0; m_up = 0;
            m_idx = 0; m_score = 0; m_cnt = 0; m_lfsr = 8'hA5;
        end else begin
            lfsr_pre = m_lfsr;
            m_lfsr   = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
            case (m_state)
                0: if (start && selected_level != 0) begin
                       m_state = 1; m_level = selected_level; m_time = 3; m_score = 0;
                   end
                1: if (tick_1hz) begin
                       if (m_time == 1) begin
                           m_state = 2; m_time = 30; m_cnt = 0; m_up = 0;
                       end else m_time = m_time - 1;
                   end
                2: begin
`ifdef PAUSE_TOGGLE_EN
                       if (pause) m_state = 4; else begin
`endif
                       if (hit && m_up == 1 && hit_idx == m_idx) begin
                           m_score = (m_score + 1 > 99) ? 99 : m_score + 1;
                           m_up = 0;
                       end
                       if (tick_fast) begin
                           m_cnt = m_cnt + 1;
                           if (m_cnt == period_of(m_level)) begin
                               m_cnt = 0; m_up = 1; m_idx = int'(lfsr_pre[2:0]);
                           end
                       end
                       if (tick_1hz) begin
                           m_time = m_time - 1;
                           if (m_time == 0) begin m_state = 3; m_up = 0; end
                       end
`ifdef PAUSE_TOGGLE_EN
                       end
`endif
                   end
                3: if (start) m_state = 0;
`ifdef PAUSE_TOGGLE_EN
                4: if (pause) m_state = 2;
`endif
                default: m_state = 0;
            endcase
        end
    end

    // Cycle-by-cycle comparison of the DUT against the model
    initial forever begin
        @(posedge clk);
        #1;
        if (!rst) begin
            check_output("game_state", game_state, (m_state == 4) ? 1 : m_state);
            check_output("active_level", active_level, m_level);
            check_output("time_left", time_left, m_time);
            check_output("mole_up", mole_up, m_up);
            check_output("mole_idx", mole_idx, m_idx);
            check_output("score", score, m_score);
`ifdef PAUSE_TOGGLE_EN
            check_output("paused", paused, (m_state == 4) ? 1 : 0);
`endif
        end
    end

    // One clock of stimulus, driven at a falling edge and cleared at the next
    task automatic apply_stimulus(input logic s, input logic t1, input logic tf,
                                  input logic h, input logic [2:0] hi);
        start = s; tick_1hz = t1; tick_fast = tf; hit = h; hit_idx = hi;
        @(negedge clk);
        start = 0; tick_1hz = 0; tick_fast = 0; hit = 0;
    endtask

    task automatic idle_cycle();
        apply_stimulus(0, 0, 0, 0, 3'd0);
    endtask

    task automatic tick_seconds(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(0, 1, 0, 0, 3'd0);
    endtask

    task automatic tick_fasts(input int n);
        for (int i = 0; i < n; i++) apply_stimulus(0, 0, 1, 0, 3'd0);
    endtask

    task automatic whack(input logic [2:0] idx);
        apply_stimulus(0, 0, 0, 1, idx);
    endtask

    task automatic begin_round(input logic [1:0] lvl);
        selected_level = lvl;
        apply_stimulus(1, 0, 0, 0, 3'd0);
        tick_seconds(3);
    endtask

`ifdef PAUSE_TOGGLE_EN
    task automatic toggle_pause();
        pause = 1;
        @(negedge clk);
        pause = 0;
    endtask
`endif

    // Directed scenario
    initial begin
        rst = 1; start = 0; selected_level = 0; tick_1hz = 0;
        tick_fast = 0; hit = 0; hit_idx = 0;
`ifdef PAUSE_TOGGLE_EN
        pause = 0;
`endif
        repeat (2) @(negedge clk);
        rst = 0;
        check_output("reset_state", game_state, 0);
        check_output("reset_score", score, 0);
        check_output("reset_time", time_left, 0);

        // start without a level is ignored
        apply_stimulus(1, 0, 0, 0, 3'd0);
        check_output("nolevel_state", game_state, 0);

        // level 2 round, READY countdown
        selected_level = 2;
        apply_stimulus(1, 0, 0, 0, 3'd0);
        check_output("ready_state", game_state, 1);
        check_output("ready_time", time_left, 3);
        check_output("ready_level", active_level, 2);
        tick_seconds(1);
        idle_cycle();
        tick_seconds(1);
        check_output("ready_time1", time_left, 1);
        apply_stimulus(0, 1, 1, 0, 3'd0);
        check_output("play_state", game_state, 2);
        check_output("play_time", time_left, 30);

        // level change and start during play are ignored
        selected_level = 3;
        apply_stimulus(1, 0, 0, 0, 3'd0);
        check_output("level_hold", active_level, 2);
        check_output("start_in_play", game_state, 2);

        tick_fasts(8);
        check_output("l2_spawn", mole_up, 1);
        whack(3'(m_idx ^ 1));
        check_output("miss_score", score, 0);
        check_output("miss_up", mole_up, 1);
        whack(3'(m_idx));
        check_output("hit_score", score, 1);
        check_output("hit_down", mole_up, 0);
        whack(3'(m_idx));
        check_output("hit_nomole", score, 1);

        tick_seconds(30);
        check_output("over_state", game_state, 3);
        check_output("over_time", time_left, 0);
        check_output("over_mole", mole_up, 0);
        whack(3'(m_idx));
        check_output("over_hit", score, 1);
        apply_stimulus(1, 0, 0, 0, 3'd0);
        check_output("over_to_idle", game_state, 0);
        check_output("idle_keep_score", score, 1);

        // level 3 round: spawning, hits and hit+spawn together
        begin_round(2'd3);
        check_output("l3_state", game_state, 2);
        check_output("l3_level", active_level, 3);
        tick_fasts(5);
        check_output("l3_spawn", mole_up, 1);
        whack(3'(m_idx));
        check_output("l3_hit", score, 1);
        check_output("l3_down", mole_up, 0);
        tick_fasts(5);
        whack(3'(m_idx ^ 1));
        check_output("l3_miss", score, 1);
        check_output("l3_miss_up", mole_up, 1);
        tick_fasts(4);
        apply_stimulus(0, 0, 1, 1, 3'(m_idx));
        check_output("both_score", score, 2);
        check_output("both_up", mole_up, 1);

        // drive the score up to saturation
        for (int i = 0; i < 200 && m_score < 99; i++) begin
            for (int j = 0; j < 20 && m_up == 0; j++) tick_fasts(1);
            whack(3'(m_idx));
        end
        check_output("score_99", score, 99);
        for (int j = 0; j < 20 && m_up == 0; j++) tick_fasts(1);
        whack(3'(m_idx));
        check_output("score_sat", score, 99);
        check_output("sat_down", mole_up, 0);
        tick_seconds(30);
        check_output("sat_over", game_state, 3);
        apply_stimulus(1, 0, 0, 0, 3'd0);
        check_output("sat_idle", game_state, 0);

        // level 1 round, optional pause, then reset mid-round
        begin_round(2'd1);
        tick_seconds(10);
        check_output("l1_time20", time_left, 20);
`ifdef PAUSE_TOGGLE_EN
        toggle_pause();
        check_output("pause_state", game_state, 1);
        check_output("pause_flag", paused, 1);
        for (int i = 0; i < 5; i++) apply_stimulus(1, 1, 1, 1, 3'(m_idx));
        check_output("pause_time", time_left, 20);
        check_output("pause_score", score, 0);
        toggle_pause();
        check_output("resume_state", game_state, 2);
        check_output("resume_flag", paused, 0);
`endif
        tick_seconds(3);
        check_output("l1_time17", time_left, 17);
        #2 rst = 1;
        #1;
        check_output("arst_state", game_state, 0);
        check_output("arst_level", active_level, 0);
        check_output("arst_time", time_left, 0);
        check_output("arst_mole", mole_up, 0);
        check_output("arst_idx", mole_idx, 0);
        check_output("arst_score", score, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;

        // a short round after reset restarts the LFSR sequence
        begin_round(2'd3);
        tick_fasts(5);
        check_output("post_rst_spawn", mole_up, 1);
        idle_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
